// File: rtl/rr_share_arbiter.sv
// Round-robin arbiter sharing one single-cycle resource among four requesters.
// A grant is held until done, request withdrawal, or MAX_HOLD cycles, then one idle cycle follows.
module rr_share_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int CW       = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] done,
  output logic [N-1:0] grant,
  output logic         grant_valid,
  output logic [1:0]   grant_id,
  output logic         timeout,
  output logic         any_req,
  output logic         dbg_state,
  output logic [1:0]   dbg_ptr
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state_q;
  logic [N-1:0]   grant_q;
  logic           grant_valid_q;
  logic [1:0]     grant_id_q;
  logic           timeout_q;
  logic [CW-1:0]  cnt_q;
  logic [1:0]     ptr_q;

  logic           pick_found_d;
  logic [1:0]     pick_id_d;
  logic [1:0]     idx;
  logic           at_max;
  logic           owner_done;
  logic           owner_req;
  logic           release_d;

  // First requester at or after the pointer, wrapping modulo N.
  always_comb begin
    pick_found_d = 1'b0;
    pick_id_d    = '0;
    idx          = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr_q + 2'(i);
      if (!pick_found_d && req[idx]) begin
        pick_found_d = 1'b1;
        pick_id_d    = idx;
      end
    end
  end

  assign at_max     = (cnt_q == CW'(MAX_HOLD));
  assign owner_done = done[grant_id_q];
  assign owner_req  = req[grant_id_q];
  assign release_d  = owner_done | ~owner_req | at_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      timeout_q     <= 1'b0;
      cnt_q         <= '0;
      ptr_q         <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          timeout_q <= 1'b0;
          if (pick_found_d) begin
            state_q       <= GRANT;
            grant_q       <= {{(N-1){1'b0}}, 1'b1} << pick_id_d;
            grant_valid_q <= 1'b1;
            grant_id_q    <= pick_id_d;
            cnt_q         <= CW'(1);
          end
        end
        GRANT: begin
          if (release_d) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            cnt_q         <= '0;
            ptr_q         <= grant_id_q + 2'd1;
            // Only a forced revocation pulses timeout; done wins a tie.
            timeout_q     <= at_max & ~owner_done & owner_req;
          end else begin
            timeout_q <= 1'b0;
            if (!at_max) cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign grant       = grant_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign timeout     = timeout_q;
  assign any_req     = |req;
  assign dbg_state   = state_q;
  assign dbg_ptr     = ptr_q;

endmodule

// File: tb/tb_rr_share_arbiter.sv
// Directed bench for rr_share_arbiter: reset, single grant, fairness, timeout,
// done/timeout collision, stray done, withdrawal and asynchronous reset.
module tb_rr_share_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic       timeout;
  logic       any_req;
  logic       dbg_state;
  logic [1:0] dbg_ptr;

  int vectors    = 0;
  int miscompares = 0;

  rr_share_arbiter #(.N(4), .MAX_HOLD(8), .CW(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .timeout     (timeout),
    .any_req     (any_req),
    .dbg_state   (dbg_state),
    .dbg_ptr     (dbg_ptr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = 4'b0000;
    done = 4'b0000;
    tick();
    tick();
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = 4'b0000;
    done = 4'b0000;
    tick();
    vectors++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0 || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got grant=%b gv=%b id=%0d to=%b, expected 0000/0/0/0",
               grant, grant_valid, grant_id, timeout);
    end
    vectors++;
    if (dbg_ptr !== 2'd0 || dbg_state !== 1'b0 || any_req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got ptr=%0d state=%b any_req=%b, expected 0/0/0", dbg_ptr, dbg_state, any_req);
    end
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req = 4'b0100;
    #1;
    vectors++;
    if (any_req !== 1'b1) begin
      miscompares++;
      $display("FAIL any_req_comb: got %b expected 1", any_req);
    end
    tick();
    vectors++;
    if (grant !== 4'b0100 || grant_id !== 2'd2 || grant_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL single_grant: got grant=%b id=%0d gv=%b, expected 0100/2/1", grant, grant_id, grant_valid);
    end
    done = 4'b0100;
    tick();
    done = 4'b0000;
    req  = 4'b0000;
    vectors++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || timeout !== 1'b0 || dbg_ptr !== 2'd3) begin
      miscompares++;
      $display("FAIL single_release: got grant=%b gv=%b to=%b ptr=%0d, expected 0000/0/0/3",
               grant, grant_valid, timeout, dbg_ptr);
    end
    tick();
  endtask

  task automatic test_fairness();
    logic [3:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      vectors++;
      if (grant !== exp_order[k]) begin
        miscompares++;
        $display("FAIL fair_grant_%0d: got %b expected %b", k, grant, exp_order[k]);
      end
      tick();
      vectors++;
      if (grant !== exp_order[k]) begin
        miscompares++;
        $display("FAIL fair_hold_%0d: got %b expected %b", k, grant, exp_order[k]);
      end
      done = exp_order[k];
      tick();
      done = 4'b0000;
      vectors++;
      if (grant !== 4'b0000 || timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL fair_release_%0d: got grant=%b to=%b expected 0000/0", k, grant, timeout);
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    int held = 1;
    req = 4'b0001;
    tick();
    for (int c = 1; c < 8; c++) begin
      tick();
      if (grant === 4'b0001 && timeout === 1'b0) held++;
    end
    vectors++;
    if (held !== 8) begin
      miscompares++;
      $display("FAIL timeout_hold_len: got %0d cycles held expected 8", held);
    end
    tick();
    vectors++;
    if (grant !== 4'b0000 || timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_pulse: got grant=%b to=%b expected 0000/1", grant, timeout);
    end
    tick();
    vectors++;
    if (grant !== 4'b0001 || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_regrant: got grant=%b to=%b expected 0001/0", grant, timeout);
    end
    req = 4'b0000;
    tick();
    vectors++;
    if (grant !== 4'b0000 || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL withdraw_release: got grant=%b to=%b expected 0000/0", grant, timeout);
    end
  endtask

  task automatic test_collision();
    req = 4'b0001;
    tick();
    for (int c = 1; c < 8; c++) tick();
    vectors++;
    if (grant !== 4'b0001) begin
      miscompares++;
      $display("FAIL collision_held: got %b expected 0001", grant);
    end
    done = 4'b0001;
    tick();
    done = 4'b0000;
    req  = 4'b0000;
    vectors++;
    if (grant !== 4'b0000 || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL collision_done_wins: got grant=%b to=%b expected 0000/0", grant, timeout);
    end
    tick();
  endtask

  task automatic test_stray_done();
    done = 4'b1111;
    tick();
    done = 4'b0000;
    req  = 4'b0010;
    tick();
    vectors++;
    if (grant !== 4'b0010 || grant_id !== 2'd1) begin
      miscompares++;
      $display("FAIL stray_grant: got grant=%b id=%0d expected 0010/1", grant, grant_id);
    end
    done = 4'b1000;
    tick();
    done = 4'b0000;
    vectors++;
    if (grant !== 4'b0010) begin
      miscompares++;
      $display("FAIL stray_ignored: got %b expected 0010", grant);
    end
    req = 4'b0000;
    tick();
    vectors++;
    if (grant !== 4'b0000 || dbg_ptr !== 2'd2) begin
      miscompares++;
      $display("FAIL stray_withdraw: got grant=%b ptr=%0d expected 0000/2", grant, dbg_ptr);
    end
    tick();
  endtask

  task automatic test_async_reset();
    req = 4'b0010;
    tick();
    vectors++;
    if (grant !== 4'b0010) begin
      miscompares++;
      $display("FAIL async_pre_grant: got %b expected 0010", grant);
    end
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_id !== 2'd0 || dbg_ptr !== 2'd0) begin
      miscompares++;
      $display("FAIL async_drop: got grant=%b gv=%b id=%0d ptr=%0d expected 0000/0/0/0",
               grant, grant_valid, grant_id, dbg_ptr);
    end
    rst = 1'b0;
    req = 4'b1010;
    tick();
    vectors++;
    if (grant !== 4'b0010 || grant_id !== 2'd1) begin
      miscompares++;
      $display("FAIL async_restart: got grant=%b id=%0d expected 0010/1", grant, grant_id);
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    done = 4'b0000;
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_collision();
    test_stray_done();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_share_arbiter.md
Name: rr_share_arbiter

Overview:
- Round-robin arbiter that shares one single-cycle logic resource (the OR-gate datapath unit) among 4 requesters.
- Grants one requester at a time and holds the grant until that requester signals done, or until a hold-timeout forces release.
- Sits between the requesting blocks and the shared gate; its one-hot grant drives the resource input mux.
- any_req is the OR-reduction of all requests, used upstream as a resource-wanted indicator.

Parameters:
- N, 4: number of requesters; fixed at 4 for this revision.
- MAX_HOLD, 8: maximum consecutive cycles a grant may be held (1..255); ≥1.
- CW, 8: width of the hold counter; must satisfy 2^CW > MAX_HOLD.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  per-requester request, level-sensitive, held until granted.
- done  input  N  per-requester release pulse; only the bit of the current grantee is honoured.
- grant  output  N  one-hot grant, registered; all-zero when idle.
- grant_valid  output  1  high whenever grant is non-zero.
- grant_id  output  2  binary index of the current grantee; 0 when idle.
- timeout  output  1  one-cycle pulse when a grant is forcibly revoked by MAX_HOLD.
- any_req  output  1  combinational OR of req[N-1:0].

Behaviour:
- Reset (async, rst=1), all registers clear immediately:
  - FSM=IDLE; grant=0, grant_valid=0, grant_id=0, timeout=0, hold counter=0.
  - Priority pointer=0 (requester 0 has highest priority first).
- FSM has two states:
  - IDLE: if req!=0, pick the first set bit searching from pointer upward with wrap (ptr, ptr+1, …, ptr+N-1 mod N). Register grant/grant_id next edge, go to GRANT, counter=1. If req==0, stay IDLE.
  - GRANT: the resource belongs to grant_id.
    - Release on done[grant_id]=1, on req[grant_id]=0 (withdrawn), or on counter==MAX_HOLD.
    - On release: pointer=(grant_id+1) mod N; grant cleared the next cycle; return to IDLE. There is always ≥1 idle cycle between grants (no back-to-back handoff).
    - Otherwise: counter increments, grant held.
- Latency:
  - req rising in IDLE to grant = 1 cycle.
  - done to grant deassert = 1 cycle.
  - Release to next grant = minimum 2 cycles.
- Timeout:
  - When the counter reaches MAX_HOLD without done, timeout pulses high for exactly the release cycle's following cycle, coincident with grant going 0.
  - timeout does not assert if done arrives in the same cycle that counter==MAX_HOLD; done takes precedence.
- done bits for non-granted requesters are ignored in all states; done in IDLE is ignored.
- Simultaneous requests: exactly one grant, chosen by the rotating pointer; never more than one grant bit set (one-hot invariant).
- Pointer wrap: after serving requester 3, pointer=0.
- Counter saturates at MAX_HOLD and never wraps.
- Reset asserted mid-grant: grant drops asynchronously that instant. After release, arbitration restarts from pointer 0.
- any_req is purely combinational; no reset dependence beyond req itself.

Test Plan:
- Reset then single request: rst 1→0, req=0100 → grant=0100, grant_id=2 one cycle later; done[2] pulse → grant=0000 next cycle, pointer=3.
- Fairness, all four request continuously, each releasing via done after 2 cycles → grant order 0001,0010,0100,1000,0001; never two bits set.
- Timeout, MAX_HOLD=8: req=0001 held, done never asserted → grant high exactly 8 cycles, timeout pulses 1 cycle as grant drops; with req still high, re-grant of 0001 2 cycles later.
- done/timeout collision: done[0] arrives on the 8th grant cycle → grant released, timeout stays 0.
- Stray done / withdrawal: grantee 1, done=1000 pulses → grant unchanged; then req[1] drops → grant=0000 next cycle, pointer=2.
- Async reset mid-grant: rst pulses between clock edges while grant=0010 → grant, grant_valid and grant_id go to 0 immediately. After release with req=1010, grant=0010 (pointer back to 0).
